// File: rtl/single_port_ram_bist.sv
// single_port_ram_bist
//   Memory self-test initiator for a single-port RAM with a registered read port.
//   On an accepted start it writes PATTERN_BASE+k to every address, reads it all back
//   and compares it, then repeats with the bitwise-inverted pattern. It reports
//   pass/fail, the total mismatch count and the location and data of the first mismatch.
//
//   Ports
//     clk           rising-edge clock, shared with the RAM
//     rst           synchronous active-high reset
//     start         begin a test (sampled only in IDLE)
//     ram_en        RAM enable
//     ram_we        RAM write enable
//     ram_address   RAM address
//     ram_data_in   RAM write data
//     ram_data_out  RAM read data, valid the cycle after a read is issued
//     busy          test in progress (WR0 .. CHK1)
//     done          one-cycle completion pulse
//     pass          no mismatches in the last completed test
//     err_count     mismatches over both passes
//     fail_address  address of the first mismatch
//     fail_data     data read at the first mismatch
module single_port_ram_bist #(
  parameter int unsigned           ADDR_WIDTH   = 3,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN_BASE = 8'hA0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_address,
  output logic [DATA_WIDTH-1:0] fail_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD0,
    S_CHK0,
    S_WR1,
    S_RD1,
    S_CHK1,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic                    cmp_en;
  logic                    cmp_inv;
  logic [ADDR_WIDTH-1:0]   cmp_addr;
  logic [DATA_WIDTH-1:0]   cmp_exp;
  logic                    mismatch;
  logic [ADDR_WIDTH+1:0]   err_next;

  // Expected data for pass 0 (inv=0) or pass 1 (inv=1) at address k.
  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic inv,
                                                     input logic [ADDR_WIDTH-1:0] k);
    logic [DATA_WIDTH-1:0] v;
    v = PATTERN_BASE + DATA_WIDTH'(k);
    return inv ? ~v : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    busy        = 1'b0;
    done        = 1'b0;
    cmp_en      = 1'b0;
    cmp_inv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WR0;
      end
      S_WR0, S_WR1: begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_address = addr_q;
        ram_data_in = exp_data(state_q == S_WR1, addr_q);
        busy        = 1'b1;
        addr_d      = addr_q + 1'b1;
        if (addr_q == '1) state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
      end
      S_RD0, S_RD1: begin
        ram_en      = 1'b1;
        ram_address = addr_q;
        busy        = 1'b1;
        addr_d      = addr_q + 1'b1;
        // Read data lags the address by one cycle, so the first read
        // cycle has nothing to compare yet.
        cmp_en      = (addr_q != '0);
        cmp_inv     = (state_q == S_RD1);
        if (addr_q == '1) state_d = (state_q == S_RD0) ? S_CHK0 : S_CHK1;
      end
      S_CHK0: begin
        busy    = 1'b1;
        cmp_en  = 1'b1;
        state_d = S_WR1;
      end
      S_CHK1: begin
        busy    = 1'b1;
        cmp_en  = 1'b1;
        cmp_inv = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The counter is 0 in CHKn, so addr_q-1 wraps to the last address,
  // which is exactly the location whose data arrives in that cycle.
  assign cmp_addr = addr_q - 1'b1;
  assign cmp_exp  = exp_data(cmp_inv, cmp_addr);
  assign mismatch = cmp_en && (ram_data_out != cmp_exp);
  assign err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count    <= '0;
      pass         <= 1'b0;
      fail_address <= '0;
      fail_data    <= '0;
    end else if (state_q == S_IDLE && start) begin
      err_count    <= '0;
      pass         <= 1'b0;
      fail_address <= '0;
      fail_data    <= '0;
    end else begin
      err_count <= err_next;
      if (mismatch && err_count == '0) begin
        fail_address <= cmp_addr;
        fail_data    <= ram_data_out;
      end
      if (state_q == S_CHK1) pass <= (err_next == '0);
    end
  end

endmodule

// File: tb/tb_single_port_ram_bist.sv
module tb_single_port_ram_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ram_en;
  logic       ram_we;
  logic [2:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [2:0] fail_address;
  logic [7:0] fail_data;

  // 0: good RAM, 1: data_out bit0 stuck-at-1, 2: pass-1 write to address 5 stores 00
  int unsigned mode = 0;
  logic [7:0]  mem [8];
  logic [7:0]  rdata;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  single_port_ram_bist #(
    .ADDR_WIDTH  (3),
    .DATA_WIDTH  (8),
    .PATTERN_BASE(8'hA0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_address(fail_address),
    .fail_data   (fail_data)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we)
        mem[ram_address] <= (mode == 2 && ram_address == 3'd5 && ram_data_in == 8'h5A)
                            ? 8'h00 : ram_data_in;
      else
        rdata <= mem[ram_address];
    end
  end
  assign ram_data_out = rdata | {7'b0, (mode == 1)};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {en, we, address, data_in, busy, done} in cycle c after the accept edge.
  function automatic logic [14:0] exp_bus(input int c);
    logic       en, we, bsy, dn;
    logic [2:0] a;
    logic [7:0] d;
    en = 0; we = 0; bsy = 0; dn = 0; a = 0; d = 0;
    if (c >= 1 && c <= 8) begin
      en = 1; we = 1; a = 3'(c - 1); d = 8'hA0 + 8'(c - 1); bsy = 1;
    end else if (c >= 9 && c <= 16) begin
      en = 1; a = 3'(c - 9); bsy = 1;
    end else if (c == 17) begin
      bsy = 1;
    end else if (c >= 18 && c <= 25) begin
      en = 1; we = 1; a = 3'(c - 18); d = ~(8'hA0 + 8'(c - 18)); bsy = 1;
    end else if (c >= 26 && c <= 33) begin
      en = 1; a = 3'(c - 26); bsy = 1;
    end else if (c == 34) begin
      bsy = 1;
    end else if (c == 35) begin
      dn = 1;
    end
    return {en, we, a, d, bsy, dn};
  endfunction

  task automatic run_test(input string name);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check($sformatf("%s_clr_err", name), err_count, 0);
    check($sformatf("%s_clr_pass", name), pass, 0);
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check($sformatf("%s_latency", name), cyc, 35);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    // reset state
    check("rst_bus", {ram_en, ram_we, ram_address, ram_data_in}, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_pass_err", {pass, err_count}, 0);
    check("rst_fail", {fail_address, fail_data}, 0);
    rst = 1'b0;
    tick();
    check("idle_bus", {ram_en, busy, done}, 0);

    // good RAM, full bus trace
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      check($sformatf("bus_c%0d", c), {ram_en, ram_we, ram_address, ram_data_in, busy, done},
            exp_bus(c));
      if (c == 1)  check("wr0_first", ram_data_in, 8'hA0);
      if (c == 8)  check("wr0_last", {ram_address, ram_data_in}, {3'd7, 8'hA7});
      if (c == 18) check("wr1_first", ram_data_in, 8'h5F);
      if (c == 25) check("wr1_last", {ram_address, ram_data_in}, {3'd7, 8'h58});
      if (c < 35) tick();
    end
    check("good_pass", pass, 1);
    check("good_err", err_count, 0);
    tick();
    check("good_idle", {done, busy, ram_en}, 0);
    check("good_hold_pass", pass, 1);

    // bit0 stuck-at-1
    mode = 1;
    run_test("stuck");
    check("stuck_err", err_count, 8);
    check("stuck_faddr", fail_address, 0);
    check("stuck_fdata", fail_data, 8'hA1);
    check("stuck_pass", pass, 0);
    tick();

    // address 5 corrupted in pass 1 only
    mode = 2;
    run_test("corrupt");
    check("corrupt_err", err_count, 1);
    check("corrupt_faddr", fail_address, 5);
    check("corrupt_fdata", fail_data, 8'h00);
    check("corrupt_pass", pass, 0);
    tick();

    // start held high throughout
    mode  = 1;
    start = 1'b1;
    tick();
    for (int c = 2; c <= 35; c++) begin
      tick();
      if (c == 20) check("held_busy_mid", {busy, ram_we}, 2'b11);
    end
    check("held_done", done, 1);
    check("held_err1", err_count, 8);
    tick();
    check("held_idle", {busy, done, ram_en}, 0);
    check("held_hold_err", err_count, 8);
    mode = 0;
    tick();
    check("held_restart", {busy, ram_we, ram_address}, {2'b11, 3'd0});
    check("held_clr_err", err_count, 0);
    begin
      int cyc;
      cyc = 1;
      while (!done && cyc < 100) begin
        tick();
        cyc++;
      end
      check("held_latency2", cyc, 35);
    end
    check("held_pass2", pass, 1);
    start = 1'b0;
    tick();

    // reset during RD0 cycle 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 12; c++) tick();
    check("rd0_c3_bus", {ram_en, ram_we, ram_address}, {2'b10, 3'd3});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_bus", {ram_en, ram_we, busy, done}, 0);
    check("rst_mid_regs", {pass, err_count, fail_address, fail_data}, 0);
    tick();
    check("rst_mid_idle", {ram_en, busy}, 0);
    run_test("after_rst");
    check("after_rst_pass", {pass, err_count}, {1'b1, 5'd0});
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
